// File: rtl/multiplier_if.sv
// Controller <-> multiplier handshake and operand/result bundle.
interface multiplier_if;
    logic        mul_rst;
    logic        mul_start;
    logic        inputa_sign;
    logic        inputb_sign;
    logic [31:0] unsign_inputa;
    logic [31:0] unsign_inputb;
    logic [63:0] mul_result;
    logic        mul_sign;
    logic        mul_ovf;
    logic        mul_done;

    modport master (
        output mul_rst, mul_start, inputa_sign, inputb_sign, unsign_inputa, unsign_inputb,
        input  mul_result, mul_sign, mul_ovf, mul_done
    );

    modport slave (
        input  mul_rst, mul_start, inputa_sign, inputb_sign, unsign_inputa, unsign_inputb,
        output mul_result, mul_sign, mul_ovf, mul_done
    );
endinterface

// File: rtl/multiplier.sv
// Sequential 32x32 unsigned shift-add multiplier, one partial product per enabled clock.
// Optional overflow flag (product wider than 32 bits) enabled by defining MUL_OVF_EN.
module multiplier (
    input  logic         clk,
    input  logic         rst,
    multiplier_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_mcand;
    logic [31:0] r_mplier;
    logic [31:0] r_acc_hi;
    logic [4:0]  r_cnt;
    logic [63:0] r_result;
    logic        r_done;

    logic        w_clear;
    logic        w_load;
    logic        w_step;
    logic        w_last;
    logic [32:0] w_sum;
    logic [63:0] w_product;

    assign w_clear = rst | bus.mul_rst;

    // Carry-inclusive add, then the 65-bit {acc, mplier} shift folds into the register writes.
    assign w_sum     = r_mplier[0] ? ({1'b0, r_acc_hi} + {1'b0, r_mcand}) : {1'b0, r_acc_hi};
    assign w_product = {w_sum, r_mplier[31:1]};

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
        if (w_clear) r_state <= IDLE;
        else         r_state <= w_state_next;
    end

    always_comb begin
        // NOTE: every output gets a default first; a missed branch would otherwise infer a latch.
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            IDLE: if (bus.mul_start) begin
                w_state_next = LOAD;
                w_load       = 1'b1;
            end
            LOAD: if (bus.mul_start) begin
                w_state_next = RUN;
                w_step       = 1'b1;
            end
            RUN: if (bus.mul_start) begin
                w_step = 1'b1;
                if (r_cnt == 5'd31) begin
                    w_last       = 1'b1;
                    w_state_next = DONE;
                end
            end
            DONE:    w_state_next = DONE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc_hi <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
        end else if (w_load) begin
            r_mcand  <= bus.unsign_inputa;
            r_mplier <= bus.unsign_inputb;
            r_acc_hi <= '0;
            r_cnt    <= '0;
        end else if (w_step) begin
            r_acc_hi <= w_sum[32:1];
            r_mplier <= {w_sum[0], r_mplier[31:1]};
            r_cnt    <= r_cnt + 5'd1;
            if (w_last) begin
                r_result <= w_product;
                r_done   <= 1'b1;
            end
        end
    end

`ifdef MUL_OVF_EN
    logic r_ovf;

    always_ff @(posedge clk) begin
        if (w_clear)     r_ovf <= 1'b0;
        else if (w_last) r_ovf <= |w_product[63:32];
    end

    assign bus.mul_ovf = r_ovf;
`else
    assign bus.mul_ovf = 1'b0;
`endif

    assign bus.mul_result = r_result;
    assign bus.mul_done   = r_done;
    assign bus.mul_sign   = bus.inputa_sign ^ bus.inputb_sign;
endmodule

// File: tb/tb_multiplier.sv
// Self-checking bench for the shift-add multiplier: scoreboard of expected products,
// latency/stall/abort/operand-hold scenarios. Honours MUL_OVF_EN for the overflow flag.
module tb_multiplier;
    logic clk;
    logic rst;

    multiplier_if bus ();

    multiplier dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] result;
        logic        ovf;
        logic        sign;
    } sb_item_t;

    sb_item_t exp_q[$];
    int       n_checks = 0;
    int       n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_ovf(input logic [63:0] p);
`ifdef MUL_OVF_EN
        return |p[63:32];
`else
        return 1'b0 & p[0];
`endif
    endfunction

    // Runs one operation from IDLE. Start is dropped on edges [stall_at, stall_at+stall_len);
    // operands are scrambled before edge chg_at to prove they are sampled only once.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sa, input logic sb, input int stall_at, input int stall_len,
                          input int chg_at, input int exp_edges);
        sb_item_t item;
        int       edges;
        logic     partial_seen;
        item.result = 64'(a) * 64'(b);
        item.ovf    = exp_ovf(item.result);
        item.sign   = sa ^ sb;
        exp_q.push_back(item);

        @(negedge clk);
        bus.unsign_inputa = a;
        bus.unsign_inputb = b;
        bus.inputa_sign   = sa;
        bus.inputb_sign   = sb;
        edges        = 0;
        partial_seen = 1'b0;
        forever begin
            bus.mul_start = !((edges + 1) >= stall_at && (edges + 1) < stall_at + stall_len);
            if (edges + 1 == chg_at) begin
                bus.unsign_inputa = 32'h0000_FFFF;
                bus.unsign_inputb = 32'h0000_FFFF;
            end
            @(posedge clk);
            edges++;
            #1;
            if (bus.mul_done === 1'b1 || edges >= 200) break;
            if (bus.mul_result !== 64'd0 || bus.mul_ovf !== 1'b0) partial_seen = 1'b1;
            @(negedge clk);
        end

        item = exp_q.pop_front();
        if (bus.mul_done !== 1'b1) begin
            check({tag, "_done_timeout"}, 64'(bus.mul_done), 64'd1);
        end else begin
            check({tag, "_latency"}, 64'(edges), 64'(exp_edges));
            check({tag, "_result"}, bus.mul_result, item.result);
            check({tag, "_ovf"}, 64'(bus.mul_ovf), 64'(item.ovf));
            check({tag, "_sign"}, 64'(bus.mul_sign), 64'(item.sign));
            check({tag, "_no_partial"}, 64'(partial_seen), 64'd0);
        end
    endtask

    task automatic clear_local(input string tag);
        @(negedge clk);
        bus.mul_start = 1'b0;
        bus.mul_rst   = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_clr_done"}, 64'(bus.mul_done), 64'd0);
        check({tag, "_clr_result"}, bus.mul_result, 64'd0);
        @(negedge clk);
        bus.mul_rst = 1'b0;
    endtask

    initial begin
        logic [63:0] held;
        bus.mul_rst       = 1'b0;
        bus.mul_start     = 1'b0;
        bus.inputa_sign   = 1'b0;
        bus.inputb_sign   = 1'b0;
        bus.unsign_inputa = '0;
        bus.unsign_inputb = '0;
        rst               = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_result", bus.mul_result, 64'd0);
        check("reset_ovf", 64'(bus.mul_ovf), 64'd0);
        check("reset_done", 64'(bus.mul_done), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("a3b5", 32'd3, 32'd5, 1'b0, 1'b0, 0, 0, 0, 33);

        // DONE is absorbing: start dropped and operands changed must not disturb the result.
        held = bus.mul_result;
        @(negedge clk);
        bus.mul_start     = 1'b0;
        bus.unsign_inputa = 32'd100;
        repeat (3) @(posedge clk);
        #1;
        check("hold_done", 64'(bus.mul_done), 64'd1);
        check("hold_result", bus.mul_result, held);
        clear_local("a3b5");

        run_op("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 0, 0, 0, 33);
        clear_local("max");

        run_op("zero", 32'd0, 32'd12345, 1'b1, 1'b0, 0, 0, 0, 33);
        clear_local("zero");

        run_op("stall", 32'd1000, 32'd1000, 1'b0, 1'b1, 10, 5, 0, 38);
        clear_local("stall");

        // Abort at iteration 10 (edge 12) with start still high: local clear must win.
        @(negedge clk);
        bus.unsign_inputa = 32'h0001_0000;
        bus.unsign_inputb = 32'h0001_0000;
        bus.mul_start     = 1'b1;
        repeat (11) @(posedge clk);
        @(negedge clk);
        bus.mul_rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_done", 64'(bus.mul_done), 64'd0);
        check("abort_result", bus.mul_result, 64'd0);
        check("abort_ovf", 64'(bus.mul_ovf), 64'd0);
        @(negedge clk);
        bus.mul_rst   = 1'b0;
        bus.mul_start = 1'b0;
        run_op("after_abort", 32'd7, 32'd6, 1'b0, 1'b0, 0, 0, 0, 33);
        clear_local("after_abort");

        run_op("opchg", 32'd9, 32'd9, 1'b0, 1'b0, 0, 0, 5, 33);
        clear_local("opchg");

        // Stall while still in LOAD (edge 2) also adds exactly one cycle per stalled edge.
        run_op("load_stall", 32'h8000_0000, 32'd4, 1'b0, 1'b0, 2, 2, 0, 35);
        clear_local("load_stall");

        // Sign output is combinational regardless of state.
        @(negedge clk);
        bus.inputa_sign = 1'b0;
        bus.inputb_sign = 1'b1;
        #1;
        check("sign_comb_01", 64'(bus.mul_sign), 64'd1);
        bus.inputa_sign = 1'b1;
        #1;
        check("sign_comb_11", 64'(bus.mul_sign), 64'd0);

        // Global reset mid-RUN overrides a held start.
        @(negedge clk);
        bus.unsign_inputa = 32'hFFFF_FFFF;
        bus.unsign_inputb = 32'h0000_0003;
        bus.mul_start     = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("grst_done", 64'(bus.mul_done), 64'd0);
        check("grst_result", bus.mul_result, 64'd0);
        @(negedge clk);
        rst           = 1'b0;
        bus.mul_start = 1'b0;
        run_op("after_grst", 32'hFFFF_FFFF, 32'd3, 1'b0, 1'b0, 0, 0, 0, 33);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/multiplier.md
# multiplier

Sequential 32x32 unsigned shift-add multiplier for the calculator datapath, the companion of the sequential divider. It takes the same sign/magnitude operand split from the operand-preparation stage and runs one partial-product iteration per enabled clock. It presents a 64-bit magnitude, a result sign and an overflow flag to the result/display stage. The controller drives it through the same local-reset, held-start and done handshake it uses for division.

## Interface
- No parameters; widths fixed at 32-bit operands, 64-bit product.
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high; global
- mul_rst  in  1  local synchronous clear from controller, active-high; same effect as rst
- mul_start  in  1  level enable; held high by controller for the whole operation
- inputa_sign  in  1  sign of operand A
- inputb_sign  in  1  sign of operand B
- unsign_inputa  in  32  magnitude of A (multiplicand)
- unsign_inputb  in  32  magnitude of B (multiplier)
- mul_result  out  64  unsigned product magnitude, registered
- mul_sign  out  1  inputa_sign ^ inputb_sign, combinational
- mul_ovf  out  1  product does not fit the 32-bit calculator range, registered
- mul_done  out  1  result valid, registered

## Operation
- FSM states: IDLE, LOAD, RUN, DONE. Reset state is IDLE.
- IDLE -> LOAD when mul_start=1.
  - Edge into LOAD captures mcand=unsign_inputa, mplier=unsign_inputb, acc_hi=0 (33 bits incl. carry), cnt=0.
- LOAD -> RUN on the next edge with mul_start=1.
- RUN iteration, on each edge with mul_start=1:
  - If mplier[0]=1, acc_hi += mcand.
  - Shift {acc_hi, mplier} right by one.
  - cnt++.
- RUN ends after 32 iterations (cnt 0..31). The final iteration edge:
  - writes mul_result = {acc_hi[31:0], mplier} with the shift applied;
  - writes mul_ovf;
  - sets mul_done=1;
  - enters DONE.
- DONE holds mul_result, mul_ovf and mul_done indefinitely. mul_start is ignored. Exit only via mul_rst or rst.
- mul_start=0 in LOAD or RUN stalls: no state, counter or datapath change.
- Operands are sampled only in IDLE->LOAD. Later operand changes are ignored.
- mul_sign tracks the sign inputs combinationally in every state. For a zero product, mul_sign is still inputa_sign ^ inputb_sign; the display stage suppresses "-0".

## Timing
- Reset values: mul_result=0, mul_ovf=0, mul_done=0, state IDLE, cnt=0, all datapath registers 0.
- rst or mul_rst takes effect on the next edge from any state, including mid-RUN. All registers and outputs return to reset values.
- rst and mul_rst override mul_start in the same cycle.
- Latency with mul_start held continuously from IDLE:
  - edge 1 enters LOAD;
  - edge 2 enters RUN;
  - edges 2..33 perform iterations 0..31 (LOAD->RUN edge is iteration 0);
  - mul_done=1 after edge 33.
- Each stalled cycle adds exactly one cycle of latency.
- mul_result and mul_ovf are 0 until the completing edge. They never show partial products.
- Iteration counter is 5 bits plus the state. There is no wrap: DONE is absorbing.

## Configuration
- Macro MUL_OVF_EN.
- Defined: mul_ovf = |product[63:32], registered at completion.
- Undefined: mul_ovf tied to 0, the detection logic is omitted, and mul_result is still the full 64-bit product.

## Test plan
- A=3, B=5, mul_start held -> mul_done rises after edge 33; mul_result=15; mul_ovf=0.
- A=B=0xFFFFFFFF -> mul_result=0xFFFFFFFE00000001; mul_ovf=1 with MUL_OVF_EN, 0 without.
- A=0, B=12345, inputa_sign=1, inputb_sign=0 -> mul_result=0; mul_sign=1; mul_ovf=0.
- A=1000, B=1000, mul_start dropped for 5 cycles mid-RUN -> mul_done after edge 38; mul_result=1000000.
- A=0x10000, B=0x10000, mul_rst pulsed at iteration 10 -> next cycle IDLE with all outputs 0. Then A=7, B=6 -> mul_result=42 after 33 edges.
- A=9, B=9, operands changed to 0xFFFF/0xFFFF during RUN -> mul_result=81.
